// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port and the shared SRAM
// command/response signals of mem_arbiter.
// slave  = arbiter view
// master = requesters + SRAM view
interface mem_arbiter_if;
  // fetch port
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  // data port
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_we;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  // shared SRAM
  logic        sram_MemREAD;
  logic [1:0]  sram_MemWrite;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  modport slave (
    input  i_req_valid, i_addr, d_req_valid, d_addr, d_wdata, d_we, sram_read_data,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output sram_MemREAD, sram_MemWrite, sram_address, sram_write_data
  );

  modport master (
    output i_req_valid, i_addr, d_req_valid, d_addr, d_wdata, d_we, sram_read_data,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  sram_MemREAD, sram_MemWrite, sram_address, sram_write_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle SRAM between an instruction-fetch port
// and a data port. One access every 2 cycles (IDLE arbitrates, ACCESS drives
// the SRAM); the response pulses in the cycle after ACCESS.
// Data wins over fetch. Define ARB_STARVE_GUARD_EN to let fetch win after
// STARVE_LIMIT consecutive data grants while a fetch is waiting.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] WRITE_IDLE = 2'b00;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic        grant_i, grant_d, starve;
  logic        lat_d;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_we;
  logic        i_rsp_valid, d_rsp_valid;
  logic [31:0] i_rsp_data, d_rsp_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  // starvation flag: fetch must win once the data streak reaches the limit
  always_comb begin
    starve = (starve_cnt == CW'(STARVE_LIMIT));
  end

  // consecutive data grants while a fetch waits; cleared by a fetch grant or an idle fetch port
  always_ff @(posedge clk) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (!bus.i_req_valid || grant_i)
      starve_cnt <= '0;
    else if (grant_d)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  // strict data priority; the limit only matters with the guard compiled in
  always_comb begin
    starve = 1'b0 & (STARVE_LIMIT == 0);
  end
`endif

  // arbitration, next state and SRAM command
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    state_next = state;
    bus.sram_MemREAD    = 1'b0;
    bus.sram_MemWrite   = WRITE_IDLE;
    bus.sram_address    = '0;
    bus.sram_write_data = '0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (bus.d_req_valid && !(starve && bus.i_req_valid))
            grant_d = 1'b1;
          else if (bus.i_req_valid)
            grant_i = 1'b1;
        end
        if (grant_i || grant_d)
          state_next = ACCESS;
      end
      ACCESS: begin
        state_next          = IDLE;
        bus.sram_MemREAD    = (lat_we == WRITE_IDLE);
        bus.sram_MemWrite   = lat_we;
        bus.sram_address    = lat_addr;
        bus.sram_write_data = lat_wdata;
      end
      default: state_next = IDLE;
    endcase
    bus.i_req_ready = grant_i;
    bus.d_req_ready = grant_d;
    bus.i_rsp_valid = i_rsp_valid;
    bus.i_rsp_data  = i_rsp_data;
    bus.d_rsp_valid = d_rsp_valid;
    bus.d_rsp_data  = d_rsp_data;
  end

  // state register and command latch on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_d     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= WRITE_IDLE;
    end else begin
      state <= state_next;
      if (grant_d) begin
        lat_d     <= 1'b1;
        lat_addr  <= bus.d_addr;
        lat_wdata <= bus.d_wdata;
        lat_we    <= bus.d_we;
      end else if (grant_i) begin
        lat_d     <= 1'b0;
        lat_addr  <= bus.i_addr;
        lat_wdata <= '0;
        lat_we    <= WRITE_IDLE;
      end
    end
  end

  // capture SRAM data at the end of ACCESS; one-cycle response pulse to the winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      d_rsp_data  <= '0;
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      if (state == ACCESS) begin
        if (lat_d) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= (lat_we == WRITE_IDLE) ? bus.sram_read_data : '0;
        end else begin
          i_rsp_valid <= 1'b1;
          i_rsp_data  <= bus.sram_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations plus a random
// phase, all watched every cycle by a transaction-level reference model
// (request queue of depth one, golden memory, response schedule).
module tb_mem_arbiter;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   sram_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM: 256 words, combinational read, lane-aligned writes on the rising edge
  logic [31:0] sram [256];
  logic [31:0] gmem [256];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] addr,
                                        input logic [31:0] wd, input logic [1:0] we);
    logic [31:0] r;
    r = old;
    case (we)
      2'b01: r[addr[1:0]*8 +: 8] = wd[7:0];
      2'b10: r[addr[1]*16 +: 16] = wd[15:0];
      2'b11: r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  assign bus.sram_read_data = sram[bus.sram_address[9:2]];

  always @(posedge clk) begin
    if (sram_en && bus.sram_MemWrite != 2'b00)
      sram[bus.sram_address[9:2]] <= merge(sram[bus.sram_address[9:2]], bus.sram_address,
                                           bus.sram_write_data, bus.sram_MemWrite);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit          started = 1'b0;
  bit          m_busy = 1'b0, m_isd = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [1:0]  m_we = '0;
  bit          m_rsp_i = 1'b0, m_rsp_d = 1'b0;
  logic [31:0] m_idata = '0, m_ddata = '0;
  int          m_streak = 0;

  always @(negedge clk) begin
    bit ei, ed, stv;
    int idx;
`ifdef ARB_STARVE_GUARD_EN
    stv = (m_streak >= STARVE_LIMIT);
`else
    stv = 1'b0;
`endif
    ed = rst_n && !m_busy && bus.d_req_valid && !(stv && bus.i_req_valid);
    ei = rst_n && !m_busy && bus.i_req_valid && !ed;
    if (started) begin
      chk("i_req_ready", {31'd0, bus.i_req_ready}, {31'd0, ei});
      chk("d_req_ready", {31'd0, bus.d_req_ready}, {31'd0, ed});
      chk("sram_MemREAD", {31'd0, bus.sram_MemREAD}, {31'd0, m_busy && m_we == 2'b00});
      chk("sram_MemWrite", {30'd0, bus.sram_MemWrite}, {30'd0, m_busy ? m_we : 2'b00});
      chk("sram_address", bus.sram_address, m_busy ? m_addr : 32'd0);
      chk("sram_write_data", bus.sram_write_data, m_busy ? m_wdata : 32'd0);
      chk("i_rsp_valid", {31'd0, bus.i_rsp_valid}, {31'd0, m_rsp_i});
      chk("d_rsp_valid", {31'd0, bus.d_rsp_valid}, {31'd0, m_rsp_d});
      chk("i_rsp_data", bus.i_rsp_data, m_idata);
      chk("d_rsp_data", bus.d_rsp_data, m_ddata);
    end
    idx = int'(m_addr[9:2]);
    if (!rst_n) begin
      // an access cut by reset still writes, but never answers
      if (m_busy && m_we != 2'b00) gmem[idx] = merge(gmem[idx], m_addr, m_wdata, m_we);
      m_busy = 0; m_rsp_i = 0; m_rsp_d = 0; m_idata = '0; m_ddata = '0; m_streak = 0;
      started = 1'b1;
    end else begin
      m_rsp_i = 0; m_rsp_d = 0;
      if (m_busy) begin
        if (m_isd) begin
          m_rsp_d = 1;
          m_ddata = (m_we == 2'b00) ? gmem[idx] : 32'd0;
          if (m_we != 2'b00) gmem[idx] = merge(gmem[idx], m_addr, m_wdata, m_we);
        end else begin
          m_rsp_i = 1;
          m_idata = gmem[idx];
        end
      end
      m_busy = ei || ed;
      if (ed) begin
        m_isd = 1; m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_we = bus.d_we;
      end else if (ei) begin
        m_isd = 0; m_addr = bus.i_addr; m_wdata = '0; m_we = 2'b00;
      end
      if (!bus.i_req_valid || ei) m_streak = 0;
      else if (ed) m_streak = m_streak + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.i_req_valid = 0; bus.i_addr = '0;
    bus.d_req_valid = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = 2'b00;
  endtask

  // one request through its handshake; returns response data and accept-to-response latency
  task automatic issue(input bit is_d, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] we, output logic [31:0] data, output int lat);
    bit ok;
    ok = 0; data = '0; lat = 0;
    if (is_d) begin
      bus.d_req_valid = 1; bus.d_addr = addr; bus.d_wdata = wd; bus.d_we = we;
    end else begin
      bus.i_req_valid = 1; bus.i_addr = addr;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (is_d ? bus.d_req_ready : bus.i_req_ready) begin ok = 1; break; end
      step();
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    step();
    idle_inputs();
    ok = 0;
    for (int n = 1; n < 10; n++) begin
      @(negedge clk);
      if (is_d ? bus.d_rsp_valid : bus.i_rsp_valid) begin
        ok = 1; lat = n; data = is_d ? bus.d_rsp_data : bus.i_rsp_data; break;
      end
      step();
    end
    chk("rsp_timeout", {31'd0, ok}, 32'd1);
    step();
  endtask

  initial begin
    logic [31:0] d;
    int lat, arb, first_i, na, nr;
    int acc_c [4];
    int rsp_c [4];

    for (int unsigned i = 0; i < 256; i++) begin
      sram[i] = (i * 32'h0101_0101) ^ 32'h5A5A_A5A5;
      gmem[i] = sram[i];
    end
    sram[32'h100 >> 2] = 32'hDEAD_BEEF;
    gmem[32'h100 >> 2] = 32'hDEAD_BEEF;
    idle_inputs();

    // reset: readies low even with requests pending
    bus.i_req_valid = 1; bus.d_req_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_i_ready", {31'd0, bus.i_req_ready}, 32'd0);
      chk("rst_d_ready", {31'd0, bus.d_req_ready}, 32'd0);
    end
    chk("rst_d_rsp_data", bus.d_rsp_data, 32'd0);
    chk("rst_memwrite", {30'd0, bus.sram_MemWrite}, 32'd0);
    idle_inputs();
    step();
    rst_n = 1; sram_en = 1;
    step();

    // fetch alone
    issue(0, 32'h100, '0, 2'b00, d, lat);
    chk("fetch_data", d, 32'hDEAD_BEEF);
    chk("fetch_latency", lat, 2);

    // word store, load, byte store, load
    issue(1, 32'h40, 32'h1122_3344, 2'b11, d, lat);
    chk("store_ack_data", d, 32'd0);
    chk("store_latency", lat, 2);
    issue(1, 32'h40, '0, 2'b00, d, lat);
    chk("load_word", d, 32'h1122_3344);
    issue(1, 32'h41, 32'h0000_00AA, 2'b01, d, lat);
    issue(1, 32'h40, '0, 2'b00, d, lat);
    chk("load_after_byte", d, 32'h1122_AA44);

    // both valid together: data first, fetch at the next IDLE
    bus.i_req_valid = 1; bus.i_addr = 32'h100;
    bus.d_req_valid = 1; bus.d_addr = 32'h40;
    @(negedge clk);
    chk("both_d_ready", {31'd0, bus.d_req_ready}, 32'd1);
    chk("both_i_ready", {31'd0, bus.i_req_ready}, 32'd0);
    step(); bus.d_req_valid = 0;
    @(negedge clk);
    chk("access_i_ready", {31'd0, bus.i_req_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("next_idle_i_ready", {31'd0, bus.i_req_ready}, 32'd1);
    step(); idle_inputs();
    repeat (3) step();

    // continuous data traffic against a waiting fetch
    bus.i_req_valid = 1; bus.i_addr = 32'h200;
    bus.d_req_valid = 1; bus.d_addr = 32'h80;
    arb = 0; first_i = 0;
    for (int k = 0; k < 40 && arb < 12; k++) begin
      @(negedge clk);
      if (bus.d_req_ready || bus.i_req_ready) begin
        arb++;
        if (bus.i_req_ready && first_i == 0) first_i = arb;
      end
      step();
    end
    chk("starve_arbitrations", arb, 12);
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_first_fetch", first_i, 5);
`else
    chk("starve_first_fetch", first_i, 0);
`endif
    idle_inputs();
    repeat (3) step();

    // back-to-back loads
    bus.d_req_valid = 1; bus.d_addr = 32'h40;
    na = 0; nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.d_req_ready && na < 4) begin acc_c[na] = cyc; na++; end
      if (bus.d_rsp_valid && nr < 4) begin rsp_c[nr] = cyc; nr++; end
      step();
    end
    idle_inputs();
    chk("b2b_accepts", na, 4);
    chk("b2b_responses", (nr >= 1) ? 32'd1 : 32'd0, 32'd1);
    if (na >= 2 && nr >= 1) begin
      chk("b2b_spacing", acc_c[1] - acc_c[0], 2);
      chk("b2b_overlap", acc_c[1], rsp_c[0]);
    end
    repeat (3) step();

    // reset during the ACCESS of a load
    bus.d_req_valid = 1; bus.d_addr = 32'h40; bus.d_we = 2'b00;
    @(negedge clk);
    chk("rstacc_accept", {31'd0, bus.d_req_ready}, 32'd1);
    step(); idle_inputs(); rst_n = 0;
    @(negedge clk);
    chk("rstacc_read_driven", {31'd0, bus.sram_MemREAD}, 32'd1);
    step(); rst_n = 1;
    @(negedge clk);
    chk("rstacc_no_rsp", {31'd0, bus.d_rsp_valid}, 32'd0);
    chk("rstacc_read_off", {31'd0, bus.sram_MemREAD}, 32'd0);
    chk("rstacc_addr_zero", bus.sram_address, 32'd0);
    chk("rstacc_rsp_data", bus.d_rsp_data, 32'd0);
    step();
    @(negedge clk);
    chk("rstacc_no_rsp_late", {31'd0, bus.d_rsp_valid}, 32'd0);
    step(); bus.d_req_valid = 1;
    @(negedge clk);
    chk("rstacc_idle_ready", {31'd0, bus.d_req_ready}, 32'd1);
    step(); idle_inputs();
    repeat (3) step();

    // random traffic, checked by the model every cycle
    for (int k = 0; k < 500; k++) begin
      bus.i_req_valid = 1'($urandom_range(0, 1));
      bus.d_req_valid = 1'($urandom_range(0, 1));
      bus.i_addr  = ($urandom_range(0, 9) == 0) ? $urandom : {22'd0, 10'($urandom_range(0, 63))};
      bus.d_addr  = ($urandom_range(0, 9) == 0) ? $urandom : {22'd0, 10'($urandom_range(0, 63))};
      bus.d_wdata = $urandom;
      bus.d_we    = 2'($urandom_range(0, 3));
      rst_n       = ($urandom_range(0, 49) != 0);
      step();
    end
    idle_inputs();
    rst_n = 1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
